mbist_march_ctrl: RTL and testbench
===================================

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: memory address width.
REQ-003 SHALL have parameter CAPACITY, default 15: highest memory address tested; the range is 0..CAPACITY inclusive.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a test.
- write_read  out  1  memory op: 1 = write, 0 = read.
- address  out  ADDR_WIDTH  memory address.
- wdata  out  DATA_WIDTH  write data.
- rdata  in  DATA_WIDTH  read data from memory.
- busy  out  1  test in progress.
- done  out  1  sticky; test complete.
- fail  out  1  sticky; one or more mismatches.
- fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- fail_elem  out  3  March element index of the first mismatch.
- err_cnt  out  8  count of mismatching reads, saturates at 255.

Function
REQ-005 SHALL run March C- in this order:
- M0 ⇑(w0)
- M1 ⇑(r0,w1)
- M2 ⇑(r1,w0)
- M3 ⇓(r0,w1)
- M4 ⇓(r1,w0)
- M5 ⇑(r0)
Background 0 = all-zeros word; background 1 = all-ones word.
REQ-006 SHALL issue exactly one memory op per clock while in RUN, with no idle cycles between ops, addresses or elements.
REQ-007 SHALL drive wdata one cycle ahead: the value on wdata in cycle t is the data for the write whose write_read=1/address appear in cycle t+1.
REQ-008 SHALL treat rdata as valid two cycles after a read op's address is presented; compares use a 2-deep pipeline carrying valid, expected value, address and element.
REQ-009 SHALL use FSM states IDLE -> RUN -> DRAIN -> DONE:
- IDLE -> RUN on start.
- RUN -> DRAIN after the last op of M5, which is the read at CAPACITY.
- DRAIN -> DONE after 2 cycles.
- DONE -> RUN on start.
REQ-010 SHALL count the address up in ascending elements, 0..CAPACITY, and down in descending elements, CAPACITY..0; at the end of an element it loads the start address of the next element without wrap errors.
REQ-011 SHALL ignore start while busy.
REQ-012 SHALL, on start from IDLE or DONE, clear done, fail, fail_addr, fail_elem and err_cnt in the same cycle.
REQ-013 SHALL compare rdata with the expected value; on a mismatch it increments err_cnt (saturating) and sets fail.
- fail_addr and fail_elem are captured only while fail=0, so they hold the first mismatch.
- A mismatch arriving in the same cycle as a start is discarded.
REQ-014 SHALL assert busy in RUN and DRAIN only; done SHALL be asserted in DONE only.
REQ-015 SHALL drive write_read=0 and address=0 whenever not in RUN.
REQ-016 SHALL take a total latency of 10*(CAPACITY+1)+2 cycles from the first RUN cycle to DONE.

Reset
REQ-017 SHALL, on rst_n low, asynchronously force:
- FSM = IDLE
- write_read=0, address=0, wdata=0
- busy=0, done=0, fail=0
- fail_addr=0, fail_elem=0, err_cnt=0
- compare pipeline valid bits cleared
REQ-018 SHALL abandon a test when reset is asserted mid-run, and issue no memory op after reset until the next start.

Structure
REQ-019 SHALL take the following from a shared package mbist_pkg:
- the FSM state enum
- March element count (6)
- per-element op count, direction and read/write data backgrounds, as constant tables
- error counter width
REQ-020 SHALL place the compare pipeline and error capture in one sub-module, mbist_cmp, fed with the read-valid, expected value, address and element.

Verification
REQ-021 Fault-free memory, CAPACITY=15, start pulse -> busy for 162 cycles, done=1, fail=0, err_cnt=0.
REQ-022 Transition fault on bit 4 (falling-edge write inverts bit 3) at address 5 -> fail=1, fail_addr=5, fail_elem=3, err_cnt>=1, done=1.
REQ-023 Stuck-at-1 on bit 0 at address 0 -> first capture fail_addr=0, fail_elem=1; err_cnt=3, from the reads in M1, M3 and M5.
REQ-024 rst_n pulsed low during M2 -> outputs return to reset values immediately; a later start runs the full test and gives done with fail=0 on fault-free memory.
REQ-025 start pulsed during RUN and during DRAIN -> ignored, with no change in op sequence or latency; start in DONE -> flags clear and a new test begins.
REQ-026 Op-trace check against golden list: cycle 0 w@0 data 0x00, cycle 16 r@0, cycle 17 w@0, then wdata 0xFF one cycle before write_read=1.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- memory BIST controller.
// Element tables are packed vectors: bit e describes March element Me.
package mbist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } mbist_state_e;

  localparam int unsigned NumElems    = 6;
  localparam int unsigned ElemWidth   = 3;
  localparam int unsigned ErrCntWidth = 8;

  localparam logic [ElemWidth-1:0] ElemLast = ElemWidth'(NumElems - 1);

  // Op count per element: bit set = two ops (read then write), clear = one op.
  localparam logic [NumElems-1:0] ElemTwoOps  = 6'b011110;
  // Address direction per element: bit set = descending.
  localparam logic [NumElems-1:0] ElemDown    = 6'b011000;
  // Element starts with a read (M0 is write-only).
  localparam logic [NumElems-1:0] ElemHasRead = 6'b111110;
  // Data backgrounds: bit set = all-ones word, clear = all-zeros word.
  localparam logic [NumElems-1:0] ElemRdOnes  = 6'b010100;
  localparam logic [NumElems-1:0] ElemWrOnes  = 6'b001010;

endpackage

// File: rtl/mbist_cmp.sv
// Read-compare pipeline and error capture for the March controller.
// A read issued in cycle t is compared against rdata in cycle t+2.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             clears sticky flags and counter (start of a test)
//   rd_valid          a read op is on the memory bus this cycle
//   exp_data          expected value for that read
//   rd_addr, rd_elem  address and March element of that read
//   rdata             memory read data (valid two cycles after the read)
//   fail              sticky mismatch flag
//   fail_addr/elem    address and element of the first mismatch
//   err_cnt           saturating mismatch count
module mbist_cmp
  import mbist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   rd_valid,
  input  logic [DATA_WIDTH-1:0]  exp_data,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [ElemWidth-1:0]   rd_elem,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [ElemWidth-1:0]   fail_elem,
  output logic [ErrCntWidth-1:0] err_cnt
);

  logic                   s1_valid_q, s2_valid_q;
  logic [DATA_WIDTH-1:0]  s1_exp_q, s2_exp_q;
  logic [ADDR_WIDTH-1:0]  s1_addr_q, s2_addr_q;
  logic [ElemWidth-1:0]   s1_elem_q, s2_elem_q;

  logic                   fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [ElemWidth-1:0]   fail_elem_q, fail_elem_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic                   mismatch;

  assign mismatch = s2_valid_q && (rdata != s2_exp_q);

  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    err_cnt_d   = err_cnt_q;
    // Clear wins: a mismatch landing in the start cycle is dropped.
    if (clear) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      err_cnt_d   = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (!fail_q) begin
        fail_addr_d = s2_addr_q;
        fail_elem_d = s2_elem_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_exp_q    <= '0;
      s2_exp_q    <= '0;
      s1_addr_q   <= '0;
      s2_addr_q   <= '0;
      s1_elem_q   <= '0;
      s2_elem_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= rd_valid;
      s2_valid_q  <= s1_valid_q;
      s1_exp_q    <= exp_data;
      s2_exp_q    <= s1_exp_q;
      s1_addr_q   <= rd_addr;
      s2_addr_q   <= s1_addr_q;
      s1_elem_q   <= rd_elem;
      s2_elem_q   <= s1_elem_q;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences one memory op per cycle over
// addresses 0..CAPACITY through elements M0..M5, then drains the compare
// pipeline for two cycles before reporting done.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle pulse starting a test (ignored while busy)
//   write_read, address   memory op (1 = write) and address, zero outside RUN
//   wdata                 write data, presented one cycle ahead of the write
//   rdata                 memory read data, valid two cycles after a read
//   busy, done            RUN/DRAIN and DONE indications
//   fail, fail_addr,
//   fail_elem, err_cnt    mismatch results
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   write_read,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0]  wdata,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [2:0]             fail_elem,
  output logic [ErrCntWidth-1:0] err_cnt
);

  localparam logic [ADDR_WIDTH-1:0] CapAddr = ADDR_WIDTH'(CAPACITY);

  mbist_state_e           state_q, state_d;
  logic [ElemWidth-1:0]   elem_q, elem_d, elem_inc;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   phase_q, phase_d;
  logic                   drain_q, drain_d;

  logic                   last_op, last_addr;
  logic                   clear, rd_valid;
  logic [DATA_WIDTH-1:0]  exp_data;

  assign elem_inc  = elem_q + 1'b1;
  assign last_op   = ElemTwoOps[elem_q] ? phase_q : 1'b1;
  assign last_addr = ElemDown[elem_q] ? (addr_q == '0) : (addr_q == CapAddr);
  assign exp_data  = ElemRdOnes[elem_q] ? '1 : '0;

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    drain_d    = drain_q;
    write_read = 1'b0;
    address    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    clear      = 1'b0;
    rd_valid   = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (start) begin
          state_d = StRun;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
          clear   = 1'b1;
        end
      end
      StRun: begin
        busy       = 1'b1;
        address    = addr_q;
        // Phase 0 is the read of read-first elements; everything else writes.
        write_read = ~ElemHasRead[elem_q] | phase_q;
        rd_valid   = ElemHasRead[elem_q] & ~phase_q;
        if (!last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = ElemDown[elem_q] ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem_q == ElemLast) begin
            state_d = StDrain;
            drain_d = 1'b0;
          end else begin
            elem_d = elem_inc;
            addr_d = ElemDown[elem_inc] ? CapAddr : '0;
          end
        end
      end
      StDrain: begin
        busy    = 1'b1;
        drain_d = 1'b1;
        if (drain_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write data tracks the element of the next op, so it leads the write by a cycle.
  assign wdata = ((state_q == StRun) && ElemWrOnes[elem_d]) ? '1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
    end
  end

  mbist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .rd_valid  (rd_valid),
    .exp_data  (exp_data),
    .rd_addr   (addr_q),
    .rd_elem   (elem_q),
    .rdata     (rdata),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

  localparam int N = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       write_read;
  logic [3:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] err_cnt;

  mbist_march_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .CAPACITY   (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .write_read (write_read),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_elem  (fail_elem),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // March C- as a table: read background (-1 none), write background (-1 none), direction.
  int elem_rd[6]   = '{-1, 0, 1, 0, 1, 0};
  int elem_wr[6]   = '{0, 1, 0, 1, 0, -1};
  int elem_down[6] = '{0, 0, 0, 1, 1, 0};

  // Fault model: 0 none, 1 stuck-at fbit=fval, 2 falling write on fbit inverts fbit2.
  int   fault_kind, fault_addr, fault_bit, fault_bit2;
  logic fault_val;
  logic [7:0] init_mem [N];
  logic [7:0] tb_mem [N];

  function automatic logic [7:0] stored_value(int a, logic [7:0] old, logic [7:0] nw);
    logic [7:0] v = nw;
    if (a == fault_addr) begin
      if (fault_kind == 1) v[fault_bit] = fault_val;
      if (fault_kind == 2 && old[fault_bit] === 1'b1 && nw[fault_bit] === 1'b0)
        v[fault_bit2] = ~nw[fault_bit2];
    end
    return v;
  endfunction

  function automatic logic [7:0] read_value(int a, logic [7:0] v);
    logic [7:0] r = v;
    if (fault_kind == 1 && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  // Memory responder: write uses last cycle's wdata, read data appears two cycles later.
  logic [7:0] rd_p0 = 8'h00, rd_p1 = 8'h00, wd_prev = 8'h00;
  initial rdata = 8'h00;
  always @(negedge clk) begin
    rdata = rd_p1;
    rd_p1 = rd_p0;
    rd_p0 = 8'h00;
    if (write_read) tb_mem[address] = stored_value(int'(address), tb_mem[address], wd_prev);
    else rd_p0 = read_value(int'(address), tb_mem[address]);
    wd_prev = wdata;
  end

  typedef struct {
    bit         wr;
    int         addr;
    logic [7:0] data;
  } op_t;

  int m_errs, m_faddr, m_felem;
  bit m_fail;

  task automatic run_test(input string tag, input bit poke);
    op_t        exp_q[$];
    logic [7:0] mm [N];
    logic [7:0] v, ev, prev_wdata;
    int         a;
    mm = init_mem;
    m_errs = 0; m_faddr = 0; m_felem = 0; m_fail = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = (elem_down[e] != 0) ? N - 1 - k : k;
        if (elem_rd[e] >= 0) begin
          exp_q.push_back('{1'b0, a, 8'h00});
          v  = read_value(a, mm[a]);
          ev = (elem_rd[e] == 1) ? 8'hFF : 8'h00;
          if (v !== ev) begin
            if (!m_fail) begin m_faddr = a; m_felem = e; m_fail = 1; end
            m_errs++;
          end
        end
        if (elem_wr[e] >= 0) begin
          ev = (elem_wr[e] == 1) ? 8'hFF : 8'h00;
          exp_q.push_back('{1'b1, a, ev});
          mm[a] = stored_value(a, mm[a], ev);
        end
      end
    end
    tb_mem = init_mem;

    @(negedge clk);
    start = 1'b1;
    prev_wdata = wdata;
    @(negedge clk);
    start = 1'b0;
    // First RUN cycle: flags already cleared by the start.
    check({tag, " clr_done"}, done, 0);
    check({tag, " clr_fail"}, fail, 0);
    check({tag, " clr_err"}, err_cnt, 0);
    check({tag, " clr_faddr"}, fail_addr, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s op%0d wr", tag, i), write_read, exp_q[i].wr);
      check($sformatf("%s op%0d addr", tag, i), address, exp_q[i].addr);
      if (exp_q[i].wr) check($sformatf("%s op%0d wdata", tag, i), prev_wdata, exp_q[i].data);
      check($sformatf("%s op%0d busy", tag, i), busy, 1);
      prev_wdata = wdata;
      start = (poke && i == 70) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " drain_busy"}, busy, 1);
    check({tag, " drain_wr"}, write_read, 0);
    check({tag, " drain_addr"}, address, 0);
    check({tag, " drain_done"}, done, 0);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " drain2_busy"}, busy, 1);
    @(negedge clk);
    check({tag, " done"}, done, 1);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " fail"}, fail, m_fail);
    check({tag, " err_cnt"}, err_cnt, (m_errs > 255) ? 255 : m_errs);
    if (m_fail) begin
      check({tag, " fail_addr"}, fail_addr, m_faddr);
      check({tag, " fail_elem"}, fail_elem, m_felem);
    end
    @(negedge clk);
    check({tag, " done_sticky"}, done, 1);
  endtask

  task automatic set_fault(input int kind, input int fa, input int fb, input int fb2,
                           input logic fv);
    fault_kind = kind; fault_addr = fa; fault_bit = fb; fault_bit2 = fb2; fault_val = fv;
  endtask

  task automatic zero_mem();
    for (int i = 0; i < N; i++) init_mem[i] = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " wr"}, write_read, 0);
    check({tag, " addr"}, address, 0);
    check({tag, " wdata"}, wdata, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " fail"}, fail, 0);
    check({tag, " faddr"}, fail_addr, 0);
    check({tag, " felem"}, fail_elem, 0);
    check({tag, " err"}, err_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_fault(0, 0, 0, 1, 1'b0);
    zero_mem();
    tb_mem = init_mem;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free memory.
    run_test("clean", 1'b0);

    // Falling write on bit 4 inverts bit 3 at address 5; starts poked in RUN and DRAIN.
    set_fault(2, 5, 4, 3, 1'b0);
    run_test("trans", 1'b1);
    check("trans fixed_addr", fail_addr, 5);
    check("trans fixed_elem", fail_elem, 3);

    // Stuck-at-1 on bit 0 at address 0.
    set_fault(1, 0, 0, 1, 1'b1);
    run_test("sa1", 1'b0);
    check("sa1 fixed_err", err_cnt, 3);
    check("sa1 fixed_elem", fail_elem, 1);

    // Reset asserted during M2 with the stuck-at fault still present.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("mid busy", busy, 1);
    check("mid fail", fail, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d wr", i), write_read, 0);
      check($sformatf("post_rst%0d busy", i), busy, 0);
    end
    set_fault(0, 0, 0, 1, 1'b0);
    run_test("after_rst", 1'b0);

    // Randomized faults and initial contents.
    for (int r = 0; r < 4; r++) begin
      int fb;
      fb = $urandom_range(0, 7);
      set_fault($urandom_range(0, 2), $urandom_range(0, N - 1), fb,
                (fb + $urandom_range(1, 7)) % 8, 1'($urandom_range(0, 1)));
      for (int i = 0; i < N; i++) init_mem[i] = 8'($urandom_range(0, 255));
      run_test($sformatf("rnd%0d", r), r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
